// File: rtl/rv_configs.sv
// Shared constants for the RV32IM execute stage: widths, func3 and branch/jump encodings, ALU ops,
// and the mul/div FSM state type.
package rv_configs;

  localparam int unsigned XlenDef = 32;

  // M-extension func3
  localparam logic [2:0] Func3Mul    = 3'b000;
  localparam logic [2:0] Func3Mulh   = 3'b001;
  localparam logic [2:0] Func3Mulhsu = 3'b010;
  localparam logic [2:0] Func3Mulhu  = 3'b011;
  localparam logic [2:0] Func3Div    = 3'b100;
  localparam logic [2:0] Func3Divu   = 3'b101;
  localparam logic [2:0] Func3Rem    = 3'b110;
  localparam logic [2:0] Func3Remu   = 3'b111;

  // Branch func3
  localparam logic [2:0] Func3Beq  = 3'b000;
  localparam logic [2:0] Func3Bne  = 3'b001;
  localparam logic [2:0] Func3Blt  = 3'b100;
  localparam logic [2:0] Func3Bge  = 3'b101;
  localparam logic [2:0] Func3Bltu = 3'b110;
  localparam logic [2:0] Func3Bgeu = 3'b111;

  localparam logic [1:0] BrJpNone   = 2'b00;
  localparam logic [1:0] BrJpBranch = 2'b01;
  localparam logic [1:0] BrJpJalr   = 2'b10;
  localparam logic [1:0] BrJpJal    = 2'b11;

  localparam logic [3:0] AluAdd   = 4'd0;
  localparam logic [3:0] AluSub   = 4'd1;
  localparam logic [3:0] AluSll   = 4'd2;
  localparam logic [3:0] AluSlt   = 4'd3;
  localparam logic [3:0] AluSltu  = 4'd4;
  localparam logic [3:0] AluXor   = 4'd5;
  localparam logic [3:0] AluSrl   = 4'd6;
  localparam logic [3:0] AluSra   = 4'd7;
  localparam logic [3:0] AluOr    = 4'd8;
  localparam logic [3:0] AluAnd   = 4'd9;
  localparam logic [3:0] AluPassB = 4'd10;

  typedef enum logic [1:0] {StIdle = 2'd0, StBusy = 2'd1, StDone = 2'd2} md_state_e;

endpackage

// File: rtl/rv_adder.sv
// Plain XLEN-bit adder with carry-in, shared by the ALU and the PC+4 path.
module rv_adder #(
  parameter int unsigned XLEN = 32
) (
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  input  logic            cin_i,
  output logic [XLEN-1:0] sum_o
);
  assign sum_o = a_i + b_i + {{(XLEN-1){1'b0}}, cin_i};
endmodule

// File: rtl/rv_alu.sv
// Single-cycle integer ALU.
module rv_alu import rv_configs::*; #(
  parameter int unsigned XLEN = XlenDef
) (
  input  logic [3:0]      ctrl_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  output logic [XLEN-1:0] res_o
);
  localparam int unsigned SW = $clog2(XLEN);

  logic            is_sub;
  logic [XLEN-1:0] b_add, sum;
  logic [SW-1:0]   shamt;

  assign is_sub = (ctrl_i == AluSub);
  assign b_add  = is_sub ? ~b_i : b_i;
  assign shamt  = b_i[SW-1:0];

  rv_adder #(.XLEN(XLEN)) u_add (.a_i(a_i), .b_i(b_add), .cin_i(is_sub), .sum_o(sum));

  always_comb begin
    res_o = sum;
    case (ctrl_i)
      AluSll:   res_o = a_i << shamt;
      AluSlt:   res_o = {{(XLEN-1){1'b0}}, $signed(a_i) < $signed(b_i)};
      AluSltu:  res_o = {{(XLEN-1){1'b0}}, a_i < b_i};
      AluXor:   res_o = a_i ^ b_i;
      AluSrl:   res_o = a_i >> shamt;
      AluSra:   res_o = XLEN'($signed(a_i) >>> shamt);
      AluOr:    res_o = a_i | b_i;
      AluAnd:   res_o = a_i & b_i;
      AluPassB: res_o = b_i;
      default:  res_o = sum;
    endcase
  end
endmodule

// File: rtl/rv_muldiv_iter.sv
// Iterative radix-2 multiply / restoring divide on operand magnitudes; signs are applied on the
// way out of DONE. Special divides and (optionally) multiplies finish straight from IDLE.
module rv_muldiv_iter import rv_configs::*; #(
  parameter int unsigned XLEN     = XlenDef,
  parameter int unsigned FAST_MUL = 0
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
  input  logic            kill_i,
  input  logic [2:0]      func3_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  output logic            idle_o,
  output logic            stall_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o
);
  localparam int unsigned CW = $clog2(XLEN);

  md_state_e       state_q;
  logic [CW-1:0]   cnt_q;
  logic [XLEN-1:0] hi_q, lo_q, dvs_q;
  logic [2:0]      f3_q;
  logic            sa_q, sb_q;

  logic            is_div, a_sgn, b_sgn, a_neg, b_neg, div_zero, div_ovf, special, fast;
  logic [XLEN-1:0] a_mag, b_mag, min_val;
  logic [2*XLEN-1:0] fast_prod, prod_fix;
  logic [XLEN:0]   mul_sum, rem_sh, rem_diff;
  logic [XLEN-1:0] quot_fix, rem_fix;

  assign is_div   = func3_i[2];
  assign a_sgn    = func3_i inside {Func3Mulh, Func3Mulhsu, Func3Div, Func3Rem};
  assign b_sgn    = func3_i inside {Func3Mulh, Func3Div, Func3Rem};
  assign a_neg    = a_sgn & a_i[XLEN-1];
  assign b_neg    = b_sgn & b_i[XLEN-1];
  assign a_mag    = a_neg ? -a_i : a_i;
  assign b_mag    = b_neg ? -b_i : b_i;
  assign min_val  = {1'b1, {(XLEN-1){1'b0}}};
  assign div_zero = is_div & (b_i == '0);
  assign div_ovf  = is_div & b_sgn & (a_i == min_val) & (b_i == '1);
  assign special  = div_zero | div_ovf;
  assign fast     = (FAST_MUL != 0) & ~is_div;
  assign fast_prod = {{XLEN{1'b0}}, a_mag} * {{XLEN{1'b0}}, b_mag};

  // lo_q holds multiplier / dividend-then-quotient, hi_q the partial product / remainder
  assign mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, dvs_q} : '0);
  assign rem_sh   = {hi_q, lo_q[XLEN-1]};
  assign rem_diff = rem_sh - {1'b0, dvs_q};

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      dvs_q   <= '0;
      f3_q    <= '0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
    end else begin
      case (state_q)
        StIdle: if (start_i) begin
          f3_q  <= func3_i;
          cnt_q <= '0;
          dvs_q <= b_mag;
          if (special) begin
            sa_q    <= 1'b0;
            sb_q    <= 1'b0;
            hi_q    <= div_zero ? a_i : '0;
            lo_q    <= div_zero ? '1 : min_val;
            state_q <= StDone;
          end else if (fast) begin
            sa_q         <= a_neg;
            sb_q         <= b_neg;
            {hi_q, lo_q} <= fast_prod;
            state_q      <= StDone;
          end else begin
            sa_q    <= a_neg;
            sb_q    <= b_neg;
            hi_q    <= '0;
            lo_q    <= a_mag;
            state_q <= StBusy;
          end
        end
        StBusy: begin
          if (kill_i) begin
            state_q <= StIdle;
          end else begin
            if (f3_q[2]) begin
              if (!rem_diff[XLEN]) begin
                hi_q <= rem_diff[XLEN-1:0];
                lo_q <= {lo_q[XLEN-2:0], 1'b1};
              end else begin
                hi_q <= rem_sh[XLEN-1:0];
                lo_q <= {lo_q[XLEN-2:0], 1'b0};
              end
            end else begin
              hi_q <= mul_sum[XLEN:1];
              lo_q <= {mul_sum[0], lo_q[XLEN-1:1]};
            end
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == CW'(XLEN - 1)) state_q <= StDone;
          end
        end
        StDone:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  assign prod_fix = (sa_q ^ sb_q) ? -{hi_q, lo_q} : {hi_q, lo_q};
  assign quot_fix = (sa_q ^ sb_q) ? -lo_q : lo_q;
  assign rem_fix  = sa_q ? -hi_q : hi_q;

  always_comb begin
    result_o = rem_fix;
    case (f3_q)
      Func3Mul:                           result_o = prod_fix[XLEN-1:0];
      Func3Mulh, Func3Mulhsu, Func3Mulhu: result_o = prod_fix[2*XLEN-1:XLEN];
      Func3Div, Func3Divu:                result_o = quot_fix;
      default:                            result_o = rem_fix;
    endcase
  end

  assign idle_o  = (state_q == StIdle);
  assign stall_o = (idle_o & start_i) | ((state_q == StBusy) & ~kill_i);
  assign done_o  = (state_q == StDone) & ~kill_i;
endmodule

// File: rtl/rv_ex_stage_muldiv.sv
// RV32IM execute stage: forwarding mux, ALU, branch resolution, iterative M-unit with stall
// handshake, and the EX/MEM pipeline register.
module rv_ex_stage_muldiv import rv_configs::*; #(
  parameter int unsigned XLEN     = XlenDef,
  parameter int unsigned NUM_FWD  = 2,
  parameter int unsigned FAST_MUL = 0,
  localparam int unsigned FS      = $clog2(NUM_FWD + 1)
) (
  input  logic                    i_exm_clk,
  input  logic                    i_exm_rst,
  input  logic                    i_exm_valid,
  input  logic                    i_exm_kill,
  input  logic [XLEN-1:0]         i_exm_pc,
  input  logic [2:0]              i_exm_func3,
  input  logic                    i_exm_is_muldiv,
  input  logic [XLEN-1:0]         i_exm_immext_res,
  input  logic [1:0]              i_exm_is_br_jp,
  input  logic                    i_exm_is_load,
  input  logic                    i_exm_dmem_we,
  input  logic                    i_exm_rf_we,
  input  logic [3:0]              i_exm_alu_ctrl,
  input  logic                    i_exm_alu_a_sel,
  input  logic                    i_exm_alu_b_sel,
  input  logic [2:0]              i_exm_dmem_bytectrl,
  input  logic [XLEN-1:0]         i_exm_rf_rd1,
  input  logic [XLEN-1:0]         i_exm_rf_rd2,
  input  logic [4:0]              i_exm_rf_wa,
  input  logic [1:0]              i_exm_rf_wd_pre_sel,
  input  logic [NUM_FWD*XLEN-1:0] i_exm_fwd_data,
  input  logic [FS-1:0]           i_exm_rd1_sel,
  input  logic [FS-1:0]           i_exm_rd2_sel,
  output logic                    o_exm_stall,
  output logic                    o_exm_flush_ifid,
  output logic [XLEN-1:0]         o_exm_if_target_addr,
  output logic                    o_exm_mem_valid,
  output logic                    o_exm_mem_is_load,
  output logic                    o_exm_mem_dmem_we,
  output logic                    o_exm_mem_rf_we,
  output logic [XLEN-1:0]         o_exm_mem_alu_res,
  output logic [XLEN-1:0]         o_exm_mem_immext_res,
  output logic [XLEN-1:0]         o_exm_mem_pc_plus_4,
  output logic [XLEN-1:0]         o_exm_mem_dmem_wd,
  output logic [2:0]              o_exm_mem_dmem_bytectrl,
  output logic [4:0]              o_exm_mem_rf_wa,
  output logic [1:0]              o_exm_mem_rf_wd_pre_sel
);
  logic [XLEN-1:0] rs1, rs2, alu_a, alu_b, alu_res, pc_plus_4, md_result;
  logic            taken, md_start, md_idle, md_stall, md_done, norm_v;
  logic [4:0]      wa_q;

  // Select codes above NUM_FWD fall back to the register file
  always_comb begin
    rs1 = i_exm_rf_rd1;
    rs2 = i_exm_rf_rd2;
    for (int k = 0; k < NUM_FWD; k++) begin
      if (int'(i_exm_rd1_sel) == k + 1) rs1 = i_exm_fwd_data[k*XLEN +: XLEN];
      if (int'(i_exm_rd2_sel) == k + 1) rs2 = i_exm_fwd_data[k*XLEN +: XLEN];
    end
  end

  assign alu_a = i_exm_alu_a_sel ? i_exm_pc : rs1;
  assign alu_b = i_exm_alu_b_sel ? rs2 : i_exm_immext_res;

  rv_alu #(.XLEN(XLEN)) u_alu (.ctrl_i(i_exm_alu_ctrl), .a_i(alu_a), .b_i(alu_b), .res_o(alu_res));

  rv_adder #(.XLEN(XLEN)) u_pc4 (
    .a_i(i_exm_pc), .b_i(XLEN'(32'd4)), .cin_i(1'b0), .sum_o(pc_plus_4)
  );

  always_comb begin
    taken = 1'b0;
    case (i_exm_is_br_jp)
      BrJpJalr, BrJpJal: taken = 1'b1;
      BrJpBranch: begin
        case (i_exm_func3)
          Func3Beq:  taken = (rs1 == rs2);
          Func3Bne:  taken = (rs1 != rs2);
          Func3Blt:  taken = ($signed(rs1) < $signed(rs2));
          Func3Bge:  taken = ($signed(rs1) >= $signed(rs2));
          Func3Bltu: taken = (rs1 < rs2);
          Func3Bgeu: taken = (rs1 >= rs2);
          default:   taken = 1'b0;
        endcase
      end
      default: taken = 1'b0;
    endcase
  end

  assign md_start = i_exm_valid & i_exm_is_muldiv & ~i_exm_kill;

  rv_muldiv_iter #(.XLEN(XLEN), .FAST_MUL(FAST_MUL)) u_md (
    .clk_i    (i_exm_clk),
    .rst_i    (i_exm_rst),
    .start_i  (md_start),
    .kill_i   (i_exm_kill),
    .func3_i  (i_exm_func3),
    .a_i      (rs1),
    .b_i      (rs2),
    .idle_o   (md_idle),
    .stall_o  (md_stall),
    .done_o   (md_done),
    .result_o (md_result)
  );

  // ID/EX may still hold an M-op while reset is asserted; keep the stall quiet then
  assign o_exm_stall          = md_stall & ~i_exm_rst;
  assign o_exm_flush_ifid     = i_exm_valid & ~i_exm_kill & ~i_exm_is_muldiv & taken;
  assign o_exm_if_target_addr = alu_res;
  assign norm_v               = md_idle & i_exm_valid & ~i_exm_kill & ~i_exm_is_muldiv;

  always_ff @(posedge i_exm_clk or posedge i_exm_rst) begin
    if (i_exm_rst) begin
      wa_q <= '0;
    end else if (md_idle & md_start) begin
      wa_q <= i_exm_rf_wa;
    end
  end

  always_ff @(posedge i_exm_clk or posedge i_exm_rst) begin
    if (i_exm_rst) begin
      o_exm_mem_valid         <= 1'b0;
      o_exm_mem_is_load       <= 1'b0;
      o_exm_mem_dmem_we       <= 1'b0;
      o_exm_mem_rf_we         <= 1'b0;
      o_exm_mem_alu_res       <= '0;
      o_exm_mem_immext_res    <= '0;
      o_exm_mem_pc_plus_4     <= '0;
      o_exm_mem_dmem_wd       <= '0;
      o_exm_mem_dmem_bytectrl <= '0;
      o_exm_mem_rf_wa         <= '0;
      o_exm_mem_rf_wd_pre_sel <= '0;
    end else begin
      o_exm_mem_immext_res    <= i_exm_immext_res;
      o_exm_mem_pc_plus_4     <= pc_plus_4;
      o_exm_mem_dmem_wd       <= rs2;
      o_exm_mem_dmem_bytectrl <= i_exm_dmem_bytectrl;
      o_exm_mem_rf_wd_pre_sel <= i_exm_rf_wd_pre_sel;
      if (md_done) begin
        o_exm_mem_valid   <= 1'b1;
        o_exm_mem_is_load <= 1'b0;
        o_exm_mem_dmem_we <= 1'b0;
        o_exm_mem_rf_we   <= 1'b1;
        o_exm_mem_alu_res <= md_result;
        o_exm_mem_rf_wa   <= wa_q;
      end else begin
        o_exm_mem_valid   <= norm_v;
        o_exm_mem_is_load <= i_exm_is_load;
        o_exm_mem_dmem_we <= i_exm_dmem_we & norm_v;
        o_exm_mem_rf_we   <= i_exm_rf_we & norm_v;
        o_exm_mem_alu_res <= alu_res;
        o_exm_mem_rf_wa   <= i_exm_rf_wa;
      end
    end
  end
endmodule
